muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle integer multiply/divide unit with architectural HI/LO registers, sitting beside the ALU in the EXE stage of the pipelined MIPS core. It executes MULT, MULTU, DIV and DIVU iteratively over 32 cycles and serves MFHI/MFLO reads. It also handles MTHI/MTLO writes. `busy` feeds the hazard detection unit so that PC and IF/ID writes are held while an operation is in flight.

## Interface
- No parameters; datapath fixed at 32 bits, iteration count fixed at 32.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `reset`  in  1  one clock; synchronous, active-high reset.
- `start`  in  1  launch operation (from ID/EXE control); sampled only in IDLE.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_val`  in  32  forwarded operand 1 (multiplicand / dividend).
- `rt_val`  in  32  forwarded operand 2 (multiplier / divisor).
- `hi_we`  in  1  MTHI write enable.
- `lo_we`  in  1  MTLO write enable.
- `wdata`  in  32  MTHI/MTLO data.
- `hi`  out  32  HI register (MFHI source).
- `lo`  out  32  LO register (MFLO source).
- `busy`  out  1  operation in flight; drives stall.
- `done`  out  1  one-cycle pulse when HI/LO take a new result.

## Operation
- States: IDLE, RUN, FIN.
- **IDLE → RUN** on `start`:
  - Latch op, operand magnitudes (absolute value for signed ops, raw value for unsigned), result signs, and a div-by-zero flag (`rt_val`==0).
  - Clear the 6-bit iteration counter.
- **RUN:** one iteration per cycle; counter increments. RUN → FIN when counter reaches 31 and that iteration completes.
  - Multiply: shift-add on a 65-bit accumulator. If the multiplier LSB is 1, add the multiplicand to the upper 33 bits, then shift the whole accumulator right by 1.
  - Divide: restoring division. Shift remainder:quotient left by 1, then trial-subtract the divisor from the 33-bit remainder. If the result is non-negative, keep it and set the quotient LSB.
- **FIN → IDLE:** sign fixup, then write HI/LO and pulse `done`.
  - MULT: negate the 64-bit product if the operand signs differ. HI = bits 63:32, LO = bits 31:0.
  - DIV: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative. LO = quotient, HI = remainder.
  - -2^31 / -1 gives LO=0x80000000, HI=0, no trap.
  - Divide by zero (DIV or DIVU) gives LO=0xFFFFFFFF and HI=`rs_val` as latched. Latency is unchanged.
- `start` while `busy` is ignored; the hazard unit guarantees it is not issued, but the block must not corrupt the in-flight operation.
- MTHI/MTLO:
  - In IDLE, `hi_we`/`lo_we` update HI/LO at the next edge.
  - While `busy`, they are ignored.
  - `start` and a write on the same IDLE edge: the write is applied, the operation launches, and the FIN result later overwrites HI/LO.

## Timing
- Reset values: `hi`=0, `lo`=0, `busy`=0, `done`=0, state IDLE, counter 0.
- Reset in any state aborts the operation. No result is written and `done` is not pulsed.
- `busy` = (state != IDLE). It is registered and rises the cycle after the start edge.
- Let E0 be the edge that samples `start`:
  - E1…E32 perform the 32 iterations.
  - At E33 HI/LO update, `done`=1 for exactly one cycle, and `busy`=0.
  - `busy` is high for 33 cycles.
- A new `start` is accepted at E33, the same edge `done` rises.
- MFHI/MFLO read `hi`/`lo` combinationally. Values read while `busy` are the previous results.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, start at E0:
  - `busy` high E1–E33 (33 cycles).
  - At E33 HI=0xFFFFFFFE, LO=0x00000001, `done` pulses once.
- MULT -3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIV -7 / 2 → LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIV 0x80000000 / -1 → LO=0x80000000, HI=0.
- DIVU 100 / 0 → LO=0xFFFFFFFF, HI=100, same 33-cycle latency.
- MTHI 0x1234 in IDLE → HI=0x1234 next cycle. Then MULTU 2×3 with `hi_we` and `start` asserted at E10 of the multiply:
  - HI/LO unchanged until E33.
  - At E33 HI=0, LO=6.
- Reset asserted at E15 of a DIVU 9/3:
  - Next edge: `busy`=0, HI=LO=0, no `done`.
  - A subsequent DIVU 9/3 gives LO=3, HI=0.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative 32-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Revision : 1.0  initial release
// ============================================================================
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [5:0] c_LAST_ITER = 6'd31;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic        r_is_div;
    logic        r_neg_res;
    logic        r_neg_rem;
    logic        r_dz;
    logic [31:0] r_rs_raw;
    logic [31:0] r_opnd_b;
    logic [64:0] r_acc;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;

    logic        w_signed;
    logic        w_rs_neg;
    logic        w_rt_neg;
    logic [31:0] w_rs_mag;
    logic [31:0] w_rt_mag;
    logic [64:0] w_acc_init;
    logic [31:0] w_opnd_b;
    logic        w_launch;
    logic [32:0] w_mul_sum;
    logic [64:0] w_mul_next;
    logic [64:0] w_div_shift;
    logic [33:0] w_div_trial;
    logic [64:0] w_div_next;
    logic [64:0] w_acc_next;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    // Operand conditioning: iterate on magnitudes, restore signs in FIN
    assign w_signed   = ~op[0];
    assign w_rs_neg   = w_signed & rs_val[31];
    assign w_rt_neg   = w_signed & rt_val[31];
    assign w_rs_mag   = w_rs_neg ? (~rs_val + 32'd1) : rs_val;
    assign w_rt_mag   = w_rt_neg ? (~rt_val + 32'd1) : rt_val;
    assign w_acc_init = op[1] ? {33'd0, w_rs_mag} : {33'd0, w_rt_mag};
    assign w_opnd_b   = op[1] ? w_rt_mag : w_rs_mag;

    // The final cycle also accepts a start so back-to-back ops lose no edge
    assign w_launch = start && ((r_state == S_IDLE) || (r_state == S_FIN));

    // Multiply step: conditional add into upper 33 bits, then shift right
    assign w_mul_sum  = r_acc[64:32] + (r_acc[0] ? {1'b0, r_opnd_b} : 33'd0);
    assign w_mul_next = {1'b0, w_mul_sum, r_acc[31:1]};

    // Divide step: remainder stays below the divisor, so bit 64 is always 0
    assign w_div_shift = {r_acc[63:0], 1'b0};
    assign w_div_trial = {1'b0, w_div_shift[64:32]} - {2'b00, r_opnd_b};
    assign w_div_next  = w_div_trial[33] ? w_div_shift
                                         : {w_div_trial[32:0], w_div_shift[31:1], 1'b1};

    assign w_acc_next = r_is_div ? w_div_next : w_mul_next;

    assign w_prod_fix = r_neg_res ? (~r_acc[63:0] + 64'd1) : r_acc[63:0];
    assign w_quo_fix  = r_neg_res ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
    assign w_rem_fix  = r_neg_rem ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

    always_comb begin
        w_res_hi = w_prod_fix[63:32];
        w_res_lo = w_prod_fix[31:0];
        if (r_is_div) begin
            if (r_dz) begin
                w_res_hi = r_rs_raw;
                w_res_lo = 32'hFFFF_FFFF;
            end else begin
                w_res_hi = w_rem_fix;
                w_res_lo = w_quo_fix;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 6'd0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dz      <= 1'b0;
            r_rs_raw  <= 32'd0;
            r_opnd_b  <= 32'd0;
            r_acc     <= 65'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (hi_we) begin
                        r_hi <= wdata;
                    end
                    if (lo_we) begin
                        r_lo <= wdata;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == c_LAST_ITER) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            if (w_launch) begin
                r_state   <= S_RUN;
                r_busy    <= 1'b1;
                r_cnt     <= 6'd0;
                r_is_div  <= op[1];
                r_neg_res <= w_rs_neg ^ w_rt_neg;
                r_neg_rem <= w_rs_neg;
                r_dz      <= (rt_val == 32'd0);
                r_rs_raw  <= rs_val;
                r_opnd_b  <= w_opnd_b;
                r_acc     <= w_acc_init;
            end
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Scoreboard bench for muldiv_unit (latency, results, HI/LO writes)
// Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] sb[$];

    localparam logic [1:0] c_MULT = 2'd0, c_MULTU = 2'd1, c_DIV = 2'd2, c_DIVU = 2'd3;

    muldiv_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .hi_we  (hi_we),
        .lo_we  (lo_we),
        .wdata  (wdata),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Scoreboard: every done pulse must match the oldest expected {HI,LO}
    always @(negedge clk) begin
        if (done === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got done=1 hi=%h lo=%h, expected no result", hi, lo);
            end else begin
                logic [63:0] exp_v;
                exp_v = sb.pop_front();
                if ({hi, lo} !== exp_v) begin
                    n_fail++;
                    $display("FAIL result: got hi=%h lo=%h, expected hi=%h lo=%h",
                             hi, lo, exp_v[63:32], exp_v[31:0]);
                end
            end
        end
    end

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sbv;
        logic [31:0] q, r;
        model = 64'd0;
        case (o)
            c_MULT: begin
                sa    = {{32{a[31]}}, a};
                sbv   = {{32{b[31]}}, b};
                model = sa * sbv;
            end
            c_MULTU: model = {32'd0, a} * {32'd0, b};
            c_DIV: begin
                if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'd0, 32'h8000_0000};
                else begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                    model = {r, q};
                end
            end
            default: begin
                if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
                else model = {a % b, a / b};
            end
        endcase
    endfunction

    // Drives start for one edge (E0) and returns at the negedge after E0
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_v);
        sb.push_back(exp_v);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0; rs_val = $urandom; rt_val = $urandom; op = 2'($urandom);
    endtask

    // Waits (bounded) for done, scrambling operands to expose missing latches
    task automatic wait_done(output int cyc, output int busy_n);
        cyc = 0;
        busy_n = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) busy_n++;
            rs_val = $urandom; rt_val = $urandom;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_tests++; if (hi !== 32'd0)  begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hi); end
        n_tests++; if (lo !== 32'd0)  begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lo); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    endtask

    task automatic test_multu_latency;
        int cyc, bn;
        launch(c_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        wait_done(cyc, bn);
        n_tests++; if (cyc != 33) begin n_fail++; $display("FAIL multu_latency: got %0d expected 33", cyc); end
        n_tests++; if (bn != 33)  begin n_fail++; $display("FAIL multu_busy_cycles: got %0d expected 33", bn); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL multu_busy_at_done: got %b expected 0", busy); end
        @(negedge clk);
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL multu_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_mult_signed;
        int cyc, bn;
        launch(c_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
        wait_done(cyc, bn);
        launch(c_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        wait_done(cyc, bn);
        n_tests++; if (cyc != 33) begin n_fail++; $display("FAIL mult_latency: got %0d expected 33", cyc); end
    endtask

    task automatic test_div;
        int cyc;
        launch(c_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        // a stray start mid-operation must not disturb it
        for (cyc = 1; cyc <= 33 && done !== 1'b1; cyc++) begin
            start = (cyc == 10); op = c_MULTU; rs_val = 32'hFFFF_FFFF; rt_val = 32'hFFFF_FFFF;
            @(negedge clk);
        end
        start = 1'b0;
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL div_stray_start_done: got %b expected 1", done); end
        @(negedge clk);
        launch(c_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
        wait_done(cyc, cyc);
        launch(c_DIV, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD});
        wait_done(cyc, cyc);
    endtask

    task automatic test_div_zero;
        int cyc, bn;
        launch(c_DIVU, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF});
        wait_done(cyc, bn);
        n_tests++; if (cyc != 33) begin n_fail++; $display("FAIL divzero_latency: got %0d expected 33", cyc); end
        launch(c_DIV, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
        wait_done(cyc, bn);
    endtask

    task automatic test_hilo_write;
        int cyc, bn;
        logic changed;
        @(negedge clk); hi_we = 1'b1; wdata = 32'h1234;
        @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5678;
        n_tests++; if (hi !== 32'h1234) begin n_fail++; $display("FAIL mthi: got %h expected 00001234", hi); end
        @(negedge clk); lo_we = 1'b0;
        n_tests++; if (lo !== 32'h5678) begin n_fail++; $display("FAIL mtlo: got %h expected 00005678", lo); end
        launch(c_MULTU, 32'd2, 32'd3, 64'd6);
        changed = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            hi_we = (i == 10); lo_we = (i == 10); start = (i == 10);
            wdata = 32'hDEAD_BEEF; op = c_DIVU; rs_val = 32'd50; rt_val = 32'd7;
            if (hi !== 32'h1234 || lo !== 32'h5678) changed = 1'b1;
            @(negedge clk);
        end
        hi_we = 1'b0; lo_we = 1'b0; start = 1'b0;
        n_tests++; if (changed) begin n_fail++; $display("FAIL hilo_busy_write: got changed=1 expected 0"); end
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL hilo_busy_done: got %b expected 1", done); end
        // write and start on the same IDLE edge
        @(negedge clk);
        sb.push_back(64'd20);
        start = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA; op = c_MULTU; rs_val = 32'd4; rt_val = 32'd5;
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0;
        n_tests++; if (lo !== 32'hAAAA) begin n_fail++; $display("FAIL start_and_write_lo: got %h expected 0000aaaa", lo); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_and_write_busy: got %b expected 1", busy); end
        wait_done(cyc, bn);
        n_tests++; if (cyc != 33) begin n_fail++; $display("FAIL start_and_write_latency: got %0d expected 33", cyc); end
    endtask

    task automatic test_reset_abort;
        int cyc, bn;
        logic seen;
        @(negedge clk);
        start = 1'b1; op = c_DIVU; rs_val = 32'd9; rt_val = 32'd3;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 15; i++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_tests++; if (hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++; $display("FAIL abort_hilo: got hi=%h lo=%h expected 0", hi, lo);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        n_tests++; if (seen) begin n_fail++; $display("FAIL abort_no_done: got done seen expected none"); end
        launch(c_DIVU, 32'd9, 32'd3, {32'd0, 32'd3});
        wait_done(cyc, bn);
    endtask

    task automatic test_back_to_back;
        int cyc, bn;
        launch(c_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
        for (int i = 1; i <= 32; i++) @(negedge clk);
        sb.push_back({32'd6, 32'd142});
        start = 1'b1; op = c_DIVU; rs_val = 32'd1000; rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0;
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got %b expected 1", done); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_busy: got %b expected 1", busy); end
        @(negedge clk);
        wait_done(cyc, bn);
        n_tests++; if (cyc != 32) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 32", cyc); end
    endtask

    task automatic test_random;
        int cyc, bn;
        logic [1:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 10; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (i == 3) b = 32'd0;
            launch(o, a, b, model(o, a, b));
            wait_done(cyc, bn);
            n_tests++; if (cyc != 33) begin n_fail++; $display("FAIL random_latency: got %0d expected 33", cyc); end
        end
    endtask

    initial begin
        test_reset();
        test_multu_latency();
        test_mult_signed();
        test_div();
        test_div_zero();
        test_hilo_write();
        test_reset_abort();
        test_back_to_back();
        test_random();
        repeat (3) @(negedge clk);
        n_tests++; if (sb.size() != 0) begin n_fail++; $display("FAIL missing_results: got %0d pending expected 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
